// File: rtl/convolution_3by3_controller.sv
// Select/enable sequencer for the 3x3 convolution datapath: feed 9 taps, drain, read 4 results.
// Optional stall input (hold) is added when CONV3_CTRL_STALL_EN is defined.
module convolution_3by3_controller #(
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [4:0] ZERO_ADDR    = 5'd25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef CONV3_CTRL_STALL_EN
  input  logic       hold,
`endif
  output logic       busy,
  output logic       done,
  output logic       sys_3by3_en,
  output logic [4:0] input_side_array_addr_in_3by3,
  output logic [4:0] input_ceiling_array_addr_in_3by3,
  output logic [4:0] filter_side_array_addr_in_3by3,
  output logic [4:0] filter_ceiling_array_addr_in_3by3,
  output logic [1:0] buffer_read_addr_in_3by3,
  output logic       out_valid,
  output logic [1:0] out_index
);

  // state | meaning
  // IDLE  | waiting for start, all selects on the zero operand
  // FEED  | tap k=0..8 driven onto the operand muxes, array enabled
  // DRAIN | zero operands, array enabled for DRAIN_CYCLES cycles
  // READ  | result buffer address walks C11, C12, C21, C22
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, FEED, DRAIN, READ, DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, tr, tc;
  logic       stall, accept;
  logic       busy_nxt, done_nxt, en_nxt, ov_nxt;
  logic [4:0] is_nxt, ic_nxt, fs_nxt, fc_nxt;
  logic [1:0] ba_nxt, oi_nxt;

`ifdef CONV3_CTRL_STALL_EN
  assign stall  = hold && (state != IDLE);
  assign accept = start && !hold;
`else
  assign stall  = 1'b0;
  assign accept = start;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!stall) begin
      case (state)
        IDLE:  if (accept) begin state_nxt = FEED; cnt_nxt = 4'd0; end
        FEED:  if (cnt == 4'd8) begin state_nxt = DRAIN; cnt_nxt = 4'd0; end
               else cnt_nxt = cnt + 4'd1;
        DRAIN: if (cnt == 4'(DRAIN_CYCLES - 1)) begin state_nxt = READ; cnt_nxt = 4'd0; end
               else cnt_nxt = cnt + 4'd1;
        READ:  if (cnt == 4'd3) begin state_nxt = DONE; cnt_nxt = 4'd0; end
               else cnt_nxt = cnt + 4'd1;
        DONE:  begin state_nxt = IDLE; cnt_nxt = 4'd0; end
        default: begin state_nxt = IDLE; cnt_nxt = 4'd0; end
      endcase
    end
  end

  // Outputs are computed from the next state so every output is a flop.
  always_comb begin
    tr       = cnt_nxt / 4'd3;
    tc       = cnt_nxt % 4'd3;
    is_nxt   = ZERO_ADDR;
    ic_nxt   = ZERO_ADDR;
    fs_nxt   = ZERO_ADDR;
    fc_nxt   = ZERO_ADDR;
    en_nxt   = 1'b0;
    ba_nxt   = 2'd0;
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    ov_nxt   = (state == READ);
    oi_nxt   = buffer_read_addr_in_3by3;
    if (stall) begin
      is_nxt = input_side_array_addr_in_3by3;
      ic_nxt = input_ceiling_array_addr_in_3by3;
      fs_nxt = filter_side_array_addr_in_3by3;
      fc_nxt = filter_ceiling_array_addr_in_3by3;
      ba_nxt = buffer_read_addr_in_3by3;
      ov_nxt = out_valid;
      oi_nxt = out_index;
    end else begin
      case (state_nxt)
        FEED: begin
          is_nxt = 5'({tr, 2'b00} + {2'b00, tc});
          ic_nxt = is_nxt + 5'd1;
          fs_nxt = 5'd16 + {1'b0, cnt_nxt};
          fc_nxt = fs_nxt;
          en_nxt = 1'b1;
        end
        DRAIN:   en_nxt = 1'b1;
        READ:    ba_nxt = cnt_nxt[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                             <= IDLE;
      cnt                               <= 4'd0;
      busy                              <= 1'b0;
      done                              <= 1'b0;
      sys_3by3_en                       <= 1'b0;
      input_side_array_addr_in_3by3     <= ZERO_ADDR;
      input_ceiling_array_addr_in_3by3  <= ZERO_ADDR;
      filter_side_array_addr_in_3by3    <= ZERO_ADDR;
      filter_ceiling_array_addr_in_3by3 <= ZERO_ADDR;
      buffer_read_addr_in_3by3          <= 2'd0;
      out_valid                         <= 1'b0;
      out_index                         <= 2'd0;
    end else begin
      state                             <= state_nxt;
      cnt                               <= cnt_nxt;
      busy                              <= busy_nxt;
      done                              <= done_nxt;
      sys_3by3_en                       <= en_nxt;
      input_side_array_addr_in_3by3     <= is_nxt;
      input_ceiling_array_addr_in_3by3  <= ic_nxt;
      filter_side_array_addr_in_3by3    <= fs_nxt;
      filter_ceiling_array_addr_in_3by3 <= fc_nxt;
      buffer_read_addr_in_3by3          <= ba_nxt;
      out_valid                         <= ov_nxt;
      out_index                         <= oi_nxt;
    end
  end

endmodule

// File: tb/tb_convolution_3by3_controller.sv
// Scoreboard bench for convolution_3by3_controller: two instances (DRAIN_CYCLES 4 and 1) share stimulus.
// Hold/stall coverage is compiled in when CONV3_CTRL_STALL_EN is defined.
module tb_convolution_3by3_controller;

  localparam logic [27:0] RST_VEC = {3'b000, 5'd25, 5'd25, 5'd25, 5'd25, 2'd0, 1'b0, 2'd0};
  localparam logic [27:0] EN_MASK = 28'h200_0000;

  logic clk = 1'b0;
  logic rst, start, hold;
  logic hold_m;
  int   n_cmp = 0;
  int   n_err = 0;

  logic       busy4, done4, en4, ov4, busy1, done1, en1, ov1;
  logic [4:0] is4, ic4, fs4, fc4, is1, ic1, fs1, fc1;
  logic [1:0] ba4, oi4, ba1, oi1;
  logic [27:0] obs4, obs1;

  always #5 clk = ~clk;

`ifdef CONV3_CTRL_STALL_EN
  assign hold_m = hold;
`else
  assign hold_m = 1'b0;
`endif

  convolution_3by3_controller #(.DRAIN_CYCLES(4), .ZERO_ADDR(5'd25)) dut4 (
    .clk(clk), .rst(rst), .start(start),
`ifdef CONV3_CTRL_STALL_EN
    .hold(hold),
`endif
    .busy(busy4), .done(done4), .sys_3by3_en(en4),
    .input_side_array_addr_in_3by3(is4), .input_ceiling_array_addr_in_3by3(ic4),
    .filter_side_array_addr_in_3by3(fs4), .filter_ceiling_array_addr_in_3by3(fc4),
    .buffer_read_addr_in_3by3(ba4), .out_valid(ov4), .out_index(oi4)
  );

  convolution_3by3_controller #(.DRAIN_CYCLES(1), .ZERO_ADDR(5'd25)) dut1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef CONV3_CTRL_STALL_EN
    .hold(hold),
`endif
    .busy(busy1), .done(done1), .sys_3by3_en(en1),
    .input_side_array_addr_in_3by3(is1), .input_ceiling_array_addr_in_3by3(ic1),
    .filter_side_array_addr_in_3by3(fs1), .filter_ceiling_array_addr_in_3by3(fc1),
    .buffer_read_addr_in_3by3(ba1), .out_valid(ov1), .out_index(oi1)
  );

  assign obs4 = {busy4, done4, en4, is4, ic4, fs4, fc4, ba4, ov4, oi4};
  assign obs1 = {busy1, done1, en1, is1, ic1, fs1, fc1, ba1, ov1, oi1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs for a run that is 'ph' cycles past the accepting edge (0 = idle).
  function automatic logic [27:0] exp_vec(input int ph, input int d);
    logic [4:0] is_v, ic_v, fs_v;
    logic [1:0] ba_v, oi_v;
    logic       en_v, ov_v;
    int         k;
    is_v = 5'd25; ic_v = 5'd25; fs_v = 5'd25;
    if (ph >= 1 && ph <= 9) begin
      k    = ph - 1;
      is_v = 5'(4 * (k / 3) + k % 3);
      ic_v = is_v + 5'd1;
      fs_v = 5'(16 + k);
    end
    en_v = (ph >= 1 && ph <= 9 + d);
    ba_v = (ph >= 10 + d && ph <= 13 + d) ? 2'(ph - 10 - d) : 2'd0;
    ov_v = (ph >= 11 + d && ph <= 14 + d);
    oi_v = ov_v ? 2'(ph - 11 - d) : 2'd0;
    return {ph != 0, ph == 14 + d, en_v, is_v, ic_v, fs_v, fs_v, ba_v, ov_v, oi_v};
  endfunction

  function automatic int next_phase(input int ph, input int d, input logic st, input logic hd);
    if (ph == 0) return (st && !hd) ? 1 : 0;
    if (hd) return ph;
    return (ph == 14 + d) ? 0 : ph + 1;
  endfunction

  int          ph4 = 0, ph1 = 0;
  logic [27:0] prev4 = RST_VEC, prev1 = RST_VEC;
  logic [27:0] q4[$], q1[$];

  always @(posedge clk) begin
    logic fr4, fr1;
    if (!rst) begin
      ph4 = 0; ph1 = 0; prev4 = RST_VEC; prev1 = RST_VEC;
    end else begin
      fr4 = hold_m && ph4 != 0;
      fr1 = hold_m && ph1 != 0;
      ph4 = next_phase(ph4, 4, start, hold_m);
      ph1 = next_phase(ph1, 1, start, hold_m);
      prev4 = fr4 ? (prev4 & ~EN_MASK) : exp_vec(ph4, 4);
      prev1 = fr1 ? (prev1 & ~EN_MASK) : exp_vec(ph1, 1);
    end
    q4.push_back(prev4);
    q1.push_back(prev1);
  end

  always @(negedge clk) begin
    if (q4.size() == 0) check("sb4_empty", 32'd0, 32'd1);
    else check("sb4", {4'd0, obs4}, {4'd0, q4.pop_front()});
    if (q1.size() == 0) check("sb1_empty", 32'd0, 32'd1);
    else check("sb1", {4'd0, obs1}, {4'd0, q1.pop_front()});
  end

  // Pulses (or holds) start, then watches done for ncyc cycles.
  task automatic run_seq(input int ncyc, input int restart_at, input int hold_at, input int hold_len,
                         input bit keep_start, output int lat4, output int lat1,
                         output int dn4, output int dn1);
    int last4, last1;
    lat4 = -1; lat1 = -1; dn4 = 0; dn1 = 0; last4 = -1; last1 = -1;
    start = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= ncyc; i++) begin
      start = keep_start || (i == restart_at);
      hold  = (hold_len > 0) && (i >= hold_at) && (i < hold_at + hold_len);
      if (done4) begin
        dn4++;
        if (lat4 < 0) lat4 = i;
        if (keep_start && last4 > 0) check("period_d4", i - last4, 19);
        last4 = i;
      end
      if (done1) begin
        dn1++;
        if (lat1 < 0) lat1 = i;
        if (keep_start && last1 > 0) check("period_d1", i - last1, 16);
        last1 = i;
      end
      @(negedge clk);
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    int lat4, lat1, dn4, dn1;
    rst = 1'b0; start = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vec4", {4'd0, obs4}, {4'd0, RST_VEC});
    check("reset_vec1", {4'd0, obs1}, {4'd0, RST_VEC});
    rst = 1'b1;
    @(negedge clk);

    run_seq(30, 0, 0, 0, 1'b0, lat4, lat1, dn4, dn1);
    check("lat_d4", lat4, 18);
    check("lat_d1", lat1, 15);
    check("dones_d4", dn4, 1);
    check("dones_d1", dn1, 1);

    run_seq(30, 5, 0, 0, 1'b0, lat4, lat1, dn4, dn1);
    check("restart_ignored_d4", dn4, 1);
    check("restart_lat_d4", lat4, 18);

    run_seq(60, 0, 0, 0, 1'b1, lat4, lat1, dn4, dn1);
    check("held_dones_d4", dn4, 3);
    check("held_dones_d1", dn1, 3);
    repeat (30) @(negedge clk);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("k4_input_side", is4, 5'd5);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst_vec4", {4'd0, obs4}, {4'd0, RST_VEC});
    check("midrun_rst_vec1", {4'd0, obs1}, {4'd0, RST_VEC});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_seq(30, 0, 0, 0, 1'b0, lat4, lat1, dn4, dn1);
    check("post_rst_lat_d4", lat4, 18);
    check("post_rst_lat_d1", lat1, 15);

`ifdef CONV3_CTRL_STALL_EN
    run_seq(35, 0, 6, 3, 1'b0, lat4, lat1, dn4, dn1);
    check("hold_lat_d4", lat4, 21);
    check("hold_lat_d1", lat1, 18);
    check("hold_dones_d4", dn4, 1);
    hold = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_blocks_start", busy4, 1'b0);
    hold = 1'b0;
    start = 1'b0;
    repeat (25) @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/convolution_3by3_controller.md
# convolution_3by3_controller

Sequencer for the 3x3 convolution datapath. After a one-cycle start request it generates, each cycle, the four 5-bit operand-mux selects (input side/ceiling, filter side/ceiling) and the systolic-array enable. It then drains the array and walks the 2-bit result-buffer read address over C11, C12, C21 and C22. It sits between the top-level control FSM and the 3x3 convolution module, replacing hand-driven select sequences.

## Interface
Parameters:
- DRAIN_CYCLES, 4, number of zero-feed cycles after the last tap; legal range 1..15
- ZERO_ADDR, 25, mux select of the zero operand; driven on all selects when not feeding taps

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin one convolution; sampled only in IDLE
- busy  output  1  high from the first FEED cycle through the DONE cycle
- done  output  1  one-cycle pulse in the DONE state
- sys_3by3_en  output  1  systolic-array enable
- input_side_array_addr_in_3by3  output  5  input-side mux select
- input_ceiling_array_addr_in_3by3  output  5  input-ceiling mux select
- filter_side_array_addr_in_3by3  output  5  filter-side mux select
- filter_ceiling_array_addr_in_3by3  output  5  filter-ceiling mux select
- buffer_read_addr_in_3by3  output  2  result-buffer read index (0=C11, 1=C12, 2=C21, 3=C22)
- out_valid  output  1  buffer data_out holds a valid result this cycle
- out_index  output  2  index of the result currently qualified by out_valid
- hold  input  1  freeze sequencer; present only with CONV3_CTRL_STALL_EN

## Operation
- States: IDLE, FEED, DRAIN, READ, DONE. All outputs are registered.
- IDLE
  - All four selects = ZERO_ADDR, sys_3by3_en=0, buffer addr=0.
  - start=1 -> FEED with tap counter k=0.
- FEED, 9 cycles, k=0..8, tap (tr,tc)=(k/3, k%3), sys_3by3_en=1:
  - filter_side = filter_ceiling = 16+k
  - input_side = 4*tr+tc
  - input_ceiling = 4*tr+tc+1
  - k=8 -> DRAIN.
- DRAIN, DRAIN_CYCLES cycles:
  - All selects = ZERO_ADDR, sys_3by3_en=1.
  - Drain counter reaching DRAIN_CYCLES-1 -> READ.
- READ, 4 cycles:
  - sys_3by3_en=0, selects = ZERO_ADDR.
  - buffer_read_addr steps 0,1,2,3.
  - Last step -> DONE.
- DONE, 1 cycle: done=1 -> IDLE.
- out_valid and out_index are the READ-state flag and buffer address delayed by one cycle, matching the registered buffer read.
- Boundary conditions:
  - start while not IDLE is ignored. No queueing.
  - start held high continuously produces back-to-back runs with one IDLE cycle between them.
  - rst asserted mid-run: immediate return to IDLE, all outputs at reset values; the partial result is discarded.
  - Counters never wrap. Each counter is cleared on state entry.
- Reset values: selects=ZERO_ADDR, sys_3by3_en=0, buffer addr=0, busy=0, done=0, out_valid=0, out_index=0.

## Timing
- start sampled high at edge T (cycle T):
  - FEED outputs visible in cycles T+1..T+9.
  - DRAIN in cycles T+10..T+9+D, where D=DRAIN_CYCLES.
  - READ addresses 0..3 in cycles T+10+D..T+13+D.
  - out_valid in cycles T+11+D..T+14+D.
  - done in cycle T+14+D, coincident with the last out_valid.
- Latency for D=4: start to done = 18 cycles.
- busy is high over T+1..T+14+D. The next start is accepted at the earliest at T+15+D.
- The selects and sys_3by3_en change only on clk rising edges; the outputs are glitch-free registered values.

## Configuration
- CONV3_CTRL_STALL_EN defined:
  - Adds the hold input.
  - hold=1 in any non-IDLE state freezes the state, all counters and all registered outputs, with one exception: sys_3by3_en is forced to 0 so the array does not advance.
  - The out_valid pipeline is also frozen.
  - hold in IDLE blocks acceptance of start.
- CONV3_CTRL_STALL_EN undefined:
  - No hold port; the sequence always runs to completion with the fixed timing above.

## Test plan
- Reset: rst=0 mid-FEED at k=4 -> next sample shows selects=25, en=0, busy=0, state IDLE. After release, start gives a clean run starting at k=0.
- Single run, D=4: 1-cycle start pulse at T.
  - Cycle T+1: selects input 0/1, filter 16/16.
  - Cycle T+9: selects input 10/11, filter 24/24.
  - en high T+1..T+13; buffer addr 0..3 at T+14..T+17.
  - out_index 0..3 with out_valid at T+15..T+18; done at T+18.
- start asserted at T+5 during FEED -> ignored; exactly one done pulse; no disturbance of the select sequence.
- start held high for 60 cycles -> runs complete every 19 cycles, each with done, separated by exactly one IDLE cycle.
- DRAIN_CYCLES=1 -> done at T+15; exactly one zero-feed cycle, with en=1 and all selects=25.
- With CONV3_CTRL_STALL_EN: hold=1 for 3 cycles at k=5 -> selects stay 21/21 and 6/7 during the hold and en=0. The sequence then resumes, and done arrives 3 cycles later than nominal.
